// File: rtl/uart_rx_fc.sv
// uart_rx_fc: 8N1 UART receiver with a small receive FIFO, a ready/valid
// output, RTS flow control and sticky frame/overrun error flags.
module uart_rx_fc #(
  parameter int FREQ_MHZ   = 16,
  parameter int BAUDS      = 115200,
  parameter int FIFO_DEPTH = 16,
  parameter int RTS_MARGIN = 4
) (
  input  logic       clk,
  input  logic       reset_ni,
  input  logic       rx_i,
  output logic       rts_o,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  input  logic       clear_i
);

  localparam int CLKS_PER_BIT = (FREQ_MHZ * 1000000) / BAUDS;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int IDX_W        = $clog2(FIFO_DEPTH);
  localparam int PTR_W        = IDX_W + 1;

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  state_t state_q, state_d;

  logic [1:0]       sync_q;
  logic             rx_s;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       idx_q;
  logic [7:0]       shift_q;
  logic             cnt_zero;

  logic load_half, load_full, dec_cnt, start_ok, sample_bit, stop_ok, stop_bad;

  logic             push_req_q;
  logic [7:0]       push_byte_q;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q, wptr_n, rptr_n, count;
  logic [PTR_W:0]   free_entries;
  logic             full, pop, do_push, drop, head_bypass;

  assign rx_s     = sync_q[1];
  assign cnt_zero = (cnt_q == '0);

  // Two-flop synchronizer; idles high so reset never looks like a start bit
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) sync_q <= 2'b11;
    else           sync_q <= {sync_q[0], rx_i};
  end

  // Receive FSM state register
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // Receive FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!rx_s) state_d = ST_START;
      ST_START: if (cnt_zero) state_d = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:  if (cnt_zero && idx_q == 3'd7) state_d = ST_STOP;
      ST_STOP:  if (cnt_zero) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Receive FSM outputs: strobes that steer the bit counter and shifter
  always_comb begin
    load_half  = 1'b0;
    load_full  = 1'b0;
    dec_cnt    = 1'b0;
    start_ok   = 1'b0;
    sample_bit = 1'b0;
    stop_ok    = 1'b0;
    stop_bad   = 1'b0;
    case (state_q)
      ST_IDLE: load_half = !rx_s;
      ST_START: begin
        if (cnt_zero) begin
          load_full = !rx_s;
          start_ok  = !rx_s;
        end else begin
          dec_cnt = 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_zero) begin
          load_full  = 1'b1;
          sample_bit = 1'b1;
        end else begin
          dec_cnt = 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_zero) begin
          stop_ok  = rx_s;
          stop_bad = !rx_s;
        end else begin
          dec_cnt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Bit-period counter, bit index and LSB-first shift register
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      if (load_half)      cnt_q <= HALF_LOAD;
      else if (load_full) cnt_q <= FULL_LOAD;
      else if (dec_cnt)   cnt_q <= cnt_q - CNT_W'(1);
      if (start_ok)        idx_q <= '0;
      else if (sample_bit) idx_q <= idx_q + 3'd1;
      if (sample_bit) shift_q[idx_q] <= rx_s;
    end
  end

  // Completed byte is staged one cycle before it is written into the FIFO
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      push_req_q  <= 1'b0;
      push_byte_q <= '0;
    end else begin
      push_req_q <= stop_ok;
      if (stop_ok) push_byte_q <= shift_q;
    end
  end

  assign count   = wptr_q - rptr_q;
  assign full    = (wptr_q[IDX_W-1:0] == rptr_q[IDX_W-1:0]) &&
                   (wptr_q[IDX_W] != rptr_q[IDX_W]);
  assign pop     = valid_o & ready_i;
  assign do_push = push_req_q & (~full | pop);
  assign drop    = push_req_q & full & ~pop;
  assign wptr_n  = wptr_q + PTR_W'(do_push);
  assign rptr_n  = rptr_q + PTR_W'(pop);
  assign head_bypass  = do_push && (wptr_q[IDX_W-1:0] == rptr_n[IDX_W-1:0]);
  assign free_entries = (PTR_W+1)'(FIFO_DEPTH) - {1'b0, count};

  // FIFO storage; contents need no reset because valid_o gates them
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q[IDX_W-1:0]] <= push_byte_q;
  end

  // FIFO pointers and registered head; a push into an empty FIFO bypasses memory
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      valid_o <= 1'b0;
      data_o  <= '0;
    end else begin
      wptr_q  <= wptr_n;
      rptr_q  <= rptr_n;
      valid_o <= (wptr_n != rptr_n);
      data_o  <= head_bypass ? push_byte_q : mem[rptr_n[IDX_W-1:0]];
    end
  end

  // RTS follows the occupancy one cycle late, with no hysteresis
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) rts_o <= 1'b0;
    else           rts_o <= (free_entries > (PTR_W+1)'(RTS_MARGIN));
  end

  // Sticky error flags; a new error wins over a simultaneous clear
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      if (stop_bad)     frame_err_o <= 1'b1;
      else if (clear_i) frame_err_o <= 1'b0;
      if (drop)         overrun_o <= 1'b1;
      else if (clear_i) overrun_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fc.sv
// tb_uart_rx_fc: drives 8N1 frames into uart_rx_fc and compares every popped
// byte, the flags and RTS against a queue-based model of the receiver.
module tb_uart_rx_fc;

  localparam int BIT_CLKS = 138;
  localparam int DEPTH    = 16;
  localparam int MARGIN   = 4;

  logic       clk = 1'b0;
  logic       reset_ni;
  logic       rx_i;
  logic       rts_o;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       frame_err_o;
  logic       overrun_o;
  logic       clear_i;

  int   checks = 0;
  int   errors = 0;
  int   pops   = 0;
  logic rand_ready = 1'b0;

  logic [7:0] exp_q[$];
  logic       exp_fe  = 1'b0;
  logic       exp_ovr = 1'b0;

  uart_rx_fc dut (
    .clk         (clk),
    .reset_ni    (reset_ni),
    .rx_i        (rx_i),
    .rts_o       (rts_o),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .clear_i     (clear_i)
  );

  // 16 MHz-style clock; only the cycle count matters to the bench
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model's view of RTS: free entries strictly above the margin
  function automatic logic expRts();
    return (DEPTH - exp_q.size()) > MARGIN;
  endfunction

  // Sends one frame; popAtStop pulses ready_i so the pop lands on the push edge
  task automatic applyStimulus(input logic [7:0] b, input logic stopBit, input logic popAtStop);
    rx_i = 1'b0;
    waitCycles(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      waitCycles(BIT_CLKS);
    end
    rx_i = stopBit;
    if (!stopBit)                                   exp_fe = 1'b1;
    else if (exp_q.size() < DEPTH || popAtStop)     exp_q.push_back(b);
    else                                            exp_ovr = 1'b1;
    if (popAtStop) begin
      waitCycles(72);
      ready_i = 1'b1;
      waitCycles(1);
      ready_i = 1'b0;
      waitCycles(BIT_CLKS - 73);
    end else begin
      waitCycles(BIT_CLKS);
    end
    rx_i = 1'b1;
  endtask

  task automatic pulseClear();
    clear_i = 1'b1;
    waitCycles(1);
    clear_i = 1'b0;
  endtask

  task automatic drainFifo(input string tag);
    ready_i = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) waitCycles(1);
    waitCycles(3);
    checkOutput({tag, "_model_drained"}, exp_q.size(), 0);
    checkOutput({tag, "_valid_idle"}, valid_o, 0);
  endtask

  // Every accepted handshake must deliver the oldest byte the model holds
  always @(negedge clk) begin
    if (reset_ni && valid_o && ready_i) begin
      pops++;
      if (exp_q.size() > 0) begin
        logic [7:0] e;
        e = exp_q.pop_front();
        checkOutput("pop_data", data_o, e);
      end else begin
        checkOutput("pop_unexpected", exp_q.size(), 1);
      end
    end
  end

  // Random back-pressure when enabled
  always @(posedge clk) begin
    #1;
    if (rand_ready) ready_i = 1'($urandom_range(0, 1));
  end

  initial begin
    int pops0;
    reset_ni = 1'b0;
    rx_i     = 1'b1;
    ready_i  = 1'b1;
    clear_i  = 1'b0;

    #1;
    checkOutput("reset_rts", rts_o, 0);
    checkOutput("reset_valid", valid_o, 0);
    checkOutput("reset_data", data_o, 0);
    checkOutput("reset_fe", frame_err_o, 0);
    checkOutput("reset_ovr", overrun_o, 0);
    waitCycles(3);
    reset_ni = 1'b1;
    waitCycles(3);
    checkOutput("post_reset_rts", rts_o, expRts());

    $display("[TB] two bytes, ready high");
    pops0 = pops;
    applyStimulus(8'h55, 1'b1, 1'b0);
    checkOutput("t1_rts_a", rts_o, 1);
    applyStimulus(8'hA3, 1'b1, 1'b0);
    waitCycles(20);
    checkOutput("t1_pop_count", pops - pops0, 2);
    checkOutput("t1_fe", frame_err_o, 0);
    checkOutput("t1_rts_b", rts_o, 1);

    $display("[TB] half-bit glitch");
    pops0 = pops;
    rx_i = 1'b0;
    waitCycles(BIT_CLKS / 2);
    rx_i = 1'b1;
    waitCycles(300);
    checkOutput("t2_valid", valid_o, 0);
    checkOutput("t2_fe", frame_err_o, 0);
    checkOutput("t2_ovr", overrun_o, 0);
    checkOutput("t2_pops", pops - pops0, 0);
    applyStimulus(8'h3C, 1'b1, 1'b0);
    drainFifo("t2");

    $display("[TB] framing error");
    applyStimulus(8'h0F, 1'b0, 1'b0);
    waitCycles(10);
    checkOutput("t3_fe_set", frame_err_o, exp_fe);
    checkOutput("t3_no_push", valid_o, 0);
    pulseClear();
    exp_fe = 1'b0;
    waitCycles(2);
    checkOutput("t3_fe_cleared", frame_err_o, exp_fe);

    $display("[TB] fill FIFO with ready low");
    ready_i = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      applyStimulus(8'(i * 17 + 3), 1'b1, 1'b0);
      checkOutput($sformatf("t4_rts_%0d", i), rts_o, expRts());
      checkOutput($sformatf("t4_ovr_%0d", i), overrun_o, exp_ovr);
    end
    checkOutput("t4_valid", valid_o, 1);
    checkOutput("t4_head", data_o, exp_q[0]);

    $display("[TB] byte completes together with a pop on a full FIFO");
    pulseClear();
    exp_ovr = 1'b0;
    waitCycles(2);
    checkOutput("t5_ovr_cleared", overrun_o, exp_ovr);
    applyStimulus(8'hEE, 1'b1, 1'b1);
    waitCycles(5);
    checkOutput("t5_no_ovr", overrun_o, exp_ovr);
    checkOutput("t5_rts", rts_o, expRts());
    checkOutput("t5_head", data_o, exp_q[0]);
    drainFifo("t5");
    checkOutput("t5_rts_after_drain", rts_o, expRts());

    $display("[TB] random bytes with random back-pressure");
    rand_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      waitCycles($urandom_range(10, 40));
      applyStimulus(8'($urandom), ($urandom_range(0, 4) != 0), 1'b0);
    end
    rand_ready = 1'b0;
    waitCycles(1);
    drainFifo("t6");
    checkOutput("t6_fe", frame_err_o, exp_fe);
    checkOutput("t6_ovr", overrun_o, exp_ovr);
    pulseClear();
    exp_fe = 1'b0;
    waitCycles(2);
    checkOutput("t6_fe_cleared", frame_err_o, exp_fe);

    $display("[TB] reset in the middle of a frame");
    ready_i = 1'b1;
    rx_i = 1'b0;
    waitCycles(BIT_CLKS);
    rx_i = 1'b1;
    waitCycles(BIT_CLKS);
    rx_i = 1'b0;
    waitCycles(2 * BIT_CLKS);
    waitCycles(BIT_CLKS / 2);
    reset_ni = 1'b0;
    #1;
    checkOutput("t7_rts", rts_o, 0);
    checkOutput("t7_valid", valid_o, 0);
    checkOutput("t7_data", data_o, 0);
    checkOutput("t7_fe", frame_err_o, 0);
    checkOutput("t7_ovr", overrun_o, 0);
    rx_i = 1'b1;
    exp_q.delete();
    exp_fe  = 1'b0;
    exp_ovr = 1'b0;
    waitCycles(4);
    reset_ni = 1'b1;
    waitCycles(200);
    checkOutput("t7_no_partial", valid_o, 0);
    pops0 = pops;
    applyStimulus(8'h42, 1'b1, 1'b0);
    drainFifo("t7");
    checkOutput("t7_pops", pops - pops0, 1);
    checkOutput("t7_fe_after", frame_err_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
